decode_stage_pipe: RTL

- Parametrised successor to the single-register instruction decode stage.
- Holds one fetched instruction plus its PC in a pipeline register with a valid/ready handshake.
- Extracts the opcode, register and immediate fields, and computes a registered PC-relative branch target.
- Sits between instruction fetch and execute; supports back-pressure, flush and an optional skid buffer.

---
 rtl/decode_stage_pipe_pkg.sv | 32 +++
 rtl/decode_stage_pipe_if.sv | 42 ++++
 rtl/decode_stage_pipe_field_extract.sv | 43 ++++
 rtl/decode_stage_pipe.sv | 136 +++++++++++++
 4 files changed

// File: rtl/decode_stage_pipe_pkg.sv
// Shared widths, decoded-field record and branch-target helper for the decode stage.
package decode_pkg;

  localparam int INST_W = 32;
  localparam int OPC_W  = 5;
  localparam int REG_W  = 4;
  localparam int IMM_W  = 16;
  localparam int OFFS_W = 27;
  localparam int PC_W   = 32;

  // Widest PC the target helper can produce; narrower PCs truncate the result.
  localparam int TGT_CALC_W = 64;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic             i_or_reg;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [1:0]       modifier;
    logic [IMM_W-1:0] imm;
  } decoded_t;

  // offset must already be sign-extended to the PC width; the caller keeps the low PC bits.
  function automatic logic [TGT_CALC_W-1:0] calc_branch_target(
    input logic [TGT_CALC_W-1:0] offset,
    input logic [TGT_CALC_W-1:0] pc
  );
    return (offset << 2) + pc;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_pipe_if #(
  parameter int INST_W = decode_pkg::INST_W,
  parameter int OPC_W  = decode_pkg::OPC_W,
  parameter int REG_W  = decode_pkg::REG_W,
  parameter int IMM_W  = decode_pkg::IMM_W,
  parameter int PC_W   = decode_pkg::PC_W
);

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [OPC_W-1:0]  out_opcode;
  logic              out_i_or_reg;
  logic [REG_W-1:0]  out_rd;
  logic [REG_W-1:0]  out_rs1;
  logic [REG_W-1:0]  out_rs2;
  logic [1:0]        out_modifier;
  logic [IMM_W-1:0]  out_imm;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_branch_target;

  // Surrounding pipeline: drives fetch beats, flush and execute's ready.
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_i_or_reg, out_rd, out_rs1,
           out_rs2, out_modifier, out_imm, out_pc, out_branch_target
  );

  // The decode stage itself.
  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_i_or_reg, out_rd, out_rs1,
           out_rs2, out_modifier, out_imm, out_pc, out_branch_target
  );

endinterface

// File: rtl/decode_stage_pipe_field_extract.sv
// Combinational slicing of an instruction word into its opcode, register and immediate fields.
module decode_field_extract #(
  parameter int INST_W = decode_pkg::INST_W,
  parameter int OPC_W  = decode_pkg::OPC_W,
  parameter int REG_W  = decode_pkg::REG_W,
  parameter int IMM_W  = decode_pkg::IMM_W
) (
  input  logic [INST_W-1:0]  inst,
  output decode_pkg::decoded_t fields
);
  import decode_pkg::*;

  localparam int IOR_BIT = INST_W - OPC_W - 1;
  localparam int RD_HI   = IOR_BIT - 1;
  localparam int RS1_HI  = RD_HI - REG_W;
  localparam int RS2_HI  = RS1_HI - REG_W;

  if (OPC_W + 1 + 3 * REG_W > INST_W) begin : g_bad_fields
    $fatal(1, "decode_field_extract: opcode and register fields exceed INST_W");
  end
  if (IMM_W > INST_W) begin : g_bad_imm
    $fatal(1, "decode_field_extract: IMM_W exceeds INST_W");
  end
  if (REG_W < 2) begin : g_bad_reg
    $fatal(1, "decode_field_extract: REG_W must hold the 2-bit modifier");
  end
  if (OPC_W > decode_pkg::OPC_W || REG_W > decode_pkg::REG_W || IMM_W > decode_pkg::IMM_W) begin : g_bad_rec
    $fatal(1, "decode_field_extract: field wider than decoded_t record");
  end

  // Narrower fields are zero-padded inside the fixed-width record.
  always_comb begin
    fields                     = '0;
    fields.opcode[OPC_W-1:0]   = inst[INST_W-1 -: OPC_W];
    fields.i_or_reg            = inst[IOR_BIT];
    fields.rd[REG_W-1:0]       = inst[RD_HI -: REG_W];
    fields.rs1[REG_W-1:0]      = inst[RS1_HI -: REG_W];
    fields.rs2[REG_W-1:0]      = inst[RS2_HI -: REG_W];
    fields.modifier            = inst[RS2_HI -: 2];
    fields.imm[IMM_W-1:0]      = inst[IMM_W-1:0];
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode pipeline register with valid/ready handshake, flush and registered branch target.
// Define DECODE_SKID_BUFFER_EN to add a one-entry skid register and a registered in_ready.
module decode_stage_pipe #(
  parameter int INST_W = decode_pkg::INST_W,
  parameter int OPC_W  = decode_pkg::OPC_W,
  parameter int REG_W  = decode_pkg::REG_W,
  parameter int IMM_W  = decode_pkg::IMM_W,
  parameter int OFFS_W = decode_pkg::OFFS_W,
  parameter int PC_W   = decode_pkg::PC_W
) (
  input  logic               clk,
  input  logic               clr,
  decode_stage_pipe_if.slave bus
);
  import decode_pkg::*;

  if (OFFS_W > INST_W || OFFS_W < 1) begin : g_bad_offs
    $fatal(1, "decode_stage_pipe: OFFS_W must be within 1..INST_W");
  end
  if (PC_W > TGT_CALC_W) begin : g_bad_pc
    $fatal(1, "decode_stage_pipe: PC_W wider than the target helper");
  end

  logic [INST_W-1:0] inst_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   target_reg;
  logic              valid_reg;

  logic [PC_W-1:0]   offs_ext;
  logic [PC_W-1:0]   in_target;
  logic              accept;
  logic              main_ready;
  decoded_t          fields;

  // Sign-extend the offset to PC width; when OFFS_W >= PC_W this just keeps the low PC_W bits.
  for (genvar gi = 0; gi < PC_W; gi++) begin : g_offs
    if (gi < OFFS_W) begin : g_keep
      assign offs_ext[gi] = bus.in_inst[gi];
    end else begin : g_sign
      assign offs_ext[gi] = bus.in_inst[OFFS_W-1];
    end
  end

  assign in_target  = PC_W'(calc_branch_target(TGT_CALC_W'(offs_ext), TGT_CALC_W'(bus.in_pc)));
  assign accept     = bus.in_valid && bus.in_ready && !bus.flush;
  assign main_ready = !valid_reg || bus.out_ready;

`ifdef DECODE_SKID_BUFFER_EN
  logic [INST_W-1:0] skid_inst_reg;
  logic [PC_W-1:0]   skid_pc_reg;
  logic [PC_W-1:0]   skid_target_reg;
  logic              skid_valid_reg;

  // Depends only on a flop, so out_ready never reaches in_ready combinationally.
  assign bus.in_ready = !skid_valid_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_reg       <= 1'b0;
      inst_reg        <= '0;
      pc_reg          <= '0;
      target_reg      <= '0;
      skid_valid_reg  <= 1'b0;
      skid_inst_reg   <= '0;
      skid_pc_reg     <= '0;
      skid_target_reg <= '0;
    end else if (bus.flush) begin
      valid_reg      <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (main_ready) begin
      if (skid_valid_reg) begin
        // in_ready was low, so no new beat competes with the skid entry.
        valid_reg      <= 1'b1;
        inst_reg       <= skid_inst_reg;
        pc_reg         <= skid_pc_reg;
        target_reg     <= skid_target_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        valid_reg <= accept;
        if (accept) begin
          inst_reg   <= bus.in_inst;
          pc_reg     <= bus.in_pc;
          target_reg <= in_target;
        end
      end
    end else if (accept) begin
      skid_valid_reg  <= 1'b1;
      skid_inst_reg   <= bus.in_inst;
      skid_pc_reg     <= bus.in_pc;
      skid_target_reg <= in_target;
    end
  end
`else
  assign bus.in_ready = main_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_reg  <= 1'b0;
      inst_reg   <= '0;
      pc_reg     <= '0;
      target_reg <= '0;
    end else if (bus.flush) begin
      valid_reg <= 1'b0;
    end else if (main_ready) begin
      valid_reg <= accept;
      if (accept) begin
        inst_reg   <= bus.in_inst;
        pc_reg     <= bus.in_pc;
        target_reg <= in_target;
      end
    end
  end
`endif

  decode_field_extract #(
    .INST_W (INST_W),
    .OPC_W  (OPC_W),
    .REG_W  (REG_W),
    .IMM_W  (IMM_W)
  ) u_extract (
    .inst   (inst_reg),
    .fields (fields)
  );

  assign bus.out_valid         = valid_reg;
  assign bus.out_opcode        = fields.opcode[OPC_W-1:0];
  assign bus.out_i_or_reg      = fields.i_or_reg;
  assign bus.out_rd            = fields.rd[REG_W-1:0];
  assign bus.out_rs1           = fields.rs1[REG_W-1:0];
  assign bus.out_rs2           = fields.rs2[REG_W-1:0];
  assign bus.out_modifier      = fields.modifier;
  assign bus.out_imm           = fields.imm[IMM_W-1:0];
  assign bus.out_pc            = pc_reg;
  assign bus.out_branch_target = target_reg;

endmodule
